// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the arbiter and the shared memory bus.
// The slave modport is the arbiter's view; master is the core-plus-memory environment.
interface mem_port_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;

  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_we;
  logic [MW-1:0] d_wmask;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;

  logic [DW-1:0] rdata;

  logic          m_req;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [MW-1:0] m_wmask;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid,
    input  d_req, d_addr, d_we, d_wmask, d_wdata,
    output d_gnt, d_rvalid,
    output rdata,
    output m_req, m_addr, m_we, m_wmask, m_wdata,
    input  m_ack, m_rvalid, m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid,
    output d_req, d_addr, d_we, d_wmask, d_wdata,
    input  d_gnt, d_rvalid,
    input  rdata,
    input  m_req, m_addr, m_we, m_wmask, m_wdata,
    output m_ack, m_rvalid, m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory bus between instruction fetch and data
// accesses: one transaction in flight, data has priority, fetch is forced after STARVE_MAX data wins.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               resetn,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned MW    = 4;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [MW-1:0] wmask;
    logic [DW-1:0] wdata;
  } bus_cmd_t;

  state_e           state_q, state_d;
  bus_cmd_t         cmd_q, cmd_d;
  logic             own_data_q, own_data_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             m_req_q, m_req_d;

  logic     any_req;
  logic     pick_fetch;
  bus_cmd_t fetch_cmd;
  bus_cmd_t data_cmd;

  // Owner selection: data wins unless fetch is alone or has waited out its starvation budget.
  assign any_req    = bus.i_req | bus.d_req;
  assign pick_fetch = bus.i_req & (~bus.d_req | (starve_q == STARVE_LIM));

  always_comb begin
    fetch_cmd       = '0;
    fetch_cmd.addr  = bus.i_addr;
    fetch_cmd.wdata = bus.d_wdata;
    data_cmd.addr   = bus.d_addr;
    data_cmd.we     = bus.d_we;
    data_cmd.wmask  = bus.d_wmask;
    data_cmd.wdata  = bus.d_wdata;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched command, owner, starvation count and bus request flop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cmd_q      <= '0;
      own_data_q <= 1'b0;
      starve_q   <= '0;
      m_req_q    <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      own_data_q <= own_data_d;
      starve_q   <= starve_d;
      m_req_q    <= m_req_d;
    end
  end

  // Next state plus the values captured at owner selection.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    own_data_d = own_data_q;
    starve_d   = starve_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = ISSUE;
          own_data_d = ~pick_fetch;
          cmd_d      = pick_fetch ? fetch_cmd : data_cmd;
          if (!pick_fetch && bus.i_req) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + CNT_W'(1);
          end else begin
            starve_d = '0;
          end
        end
      end
      ISSUE: begin
        // A response in the accept cycle is not honoured; only m_ack moves us on.
        if (bus.m_ack) begin
          state_d = cmd_q.we ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (bus.m_rvalid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    m_req_d = (state_d == ISSUE);
  end

  // Grant/valid pulses follow the memory handshake in the same cycle; reset squashes them.
  always_comb begin
    bus.i_gnt    = 1'b0;
    bus.d_gnt    = 1'b0;
    bus.i_rvalid = 1'b0;
    bus.d_rvalid = 1'b0;
    if (resetn) begin
      unique case (state_q)
        ISSUE: begin
          bus.i_gnt = bus.m_ack & ~own_data_q;
          bus.d_gnt = bus.m_ack &  own_data_q;
        end
        WAIT: begin
          bus.i_rvalid = bus.m_rvalid & ~own_data_q;
          bus.d_rvalid = bus.m_rvalid &  own_data_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_addr  = cmd_q.addr;
  assign bus.m_we    = cmd_q.we;
  assign bus.m_wmask = cmd_q.wmask;
  assign bus.m_wdata = cmd_q.wdata;
  assign bus.rdata   = bus.m_rdata;

  // Protocol sanity: one grant at a time, command held steady while waiting for acceptance.
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!resetn)
    !(bus.i_gnt && bus.d_gnt));
  a_rvalid_onehot : assert property (@(posedge clk) disable iff (!resetn)
    !(bus.i_rvalid && bus.d_rvalid));
  a_cmd_stable : assert property (@(posedge clk) disable iff (!resetn)
    (state_q == ISSUE && !bus.m_ack) |=> $stable(cmd_q));

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Arbitrates one single-ported, variable-latency memory/IO bus between the core's instruction-fetch requester (read-only) and data requester (load/store).
- Handles one transaction at a time.
- Priority is fixed: data wins over fetch, with a starvation guard that forces a fetch grant after STARVE_MAX consecutive data wins.
- Sits between the pipelined core's fetch/memory stages and the unified PROGROM/DATARAM/IO bus, replacing the split instruction/data arrays.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while fetch waits; range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  fetch accepted by memory this cycle.
- i_rvalid  out  1  fetch data valid this cycle.
- d_req  in  1  data request; held until d_gnt.
- d_addr  in  32  data byte address.
- d_we  in  1  1 = store, 0 = load.
- d_wmask  in  4  byte write enables.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted by memory this cycle.
- d_rvalid  out  1  load data valid this cycle.
- rdata  out  32  read data, shared by both requesters; equals m_rdata.
- m_req  out  1  bus request.
- m_addr  out  32  bus address.
- m_we  out  1  bus write flag.
- m_wmask  out  4  bus byte mask.
- m_wdata  out  32  bus write data.
- m_ack  in  1  memory accepts the current m_req.
- m_rvalid  in  1  read response valid.
- m_rdata  in  32  read response data.

## Operation
States: IDLE, ISSUE, WAIT.

IDLE:
- Samples i_req and d_req each cycle.
- Both requests low: stay in IDLE.
- Otherwise select an owner:
  - fetch if only i_req is high;
  - fetch if both are high and starve_cnt == STARVE_MAX;
  - data in every other case.
- Latches address, we, wmask and wdata into m_* registers. For a fetch owner, m_we=0 and m_wmask=0000.
- Next state: ISSUE.

ISSUE:
- m_req=1; m_* outputs stay stable.
- m_ack=1: owner's gnt is high this cycle (combinational: state==ISSUE & owner & m_ack).
  - Write: go to IDLE; no response is produced.
  - Read: go to WAIT.

WAIT:
- m_req=0.
- m_rvalid=1: owner's rvalid is high this cycle (combinational); go to IDLE.

Starvation counter starve_cnt:
- 4-bit, updated only when an owner is selected in IDLE.
- Data owner selected while i_req high: +1, saturating at STARVE_MAX.
- Fetch owner selected, or i_req low: cleared to 0.

Boundary rules:
- Latched values are used for the whole transaction; requester inputs are ignored after selection.
- Dropping req before it is sampled in IDLE is legal. Dropping req after selection has no effect.
- m_rvalid outside WAIT is ignored. A non-owner never sees gnt or rvalid.
- m_ack and m_rvalid arriving in the same ISSUE cycle: only m_ack is honoured; memory must not respond before acceptance.
- Reset mid-transaction: next state IDLE and outputs at reset values; the in-flight response is dropped, with no rvalid to any requester.

## Timing
Reset values:
- state=IDLE, starve_cnt=0.
- m_req=0, m_we=0, m_wmask=0, m_addr=0, m_wdata=0.
- i_gnt, d_gnt, i_rvalid, d_rvalid all 0.

Latency, with request first seen in cycle N:
- m_req is high in N+1.
- With zero-wait memory (m_ack in N+1, m_rvalid in N+2): gnt in N+1, rvalid/rdata in N+2.
- Each memory wait cycle adds one cycle.

Throughput:
- Back-to-back reads: one per 3 cycles.
- Back-to-back writes: one per 2 cycles.

gnt and rvalid are single-cycle pulses.

## Test plan
- Single fetch: i_req=1, i_addr=0x40, zero-wait memory returning 0x12345678 -> m_req in cycle 1 with m_addr=0x40, m_we=0; i_gnt in cycle 1; i_rvalid with rdata=0x12345678 in cycle 2; d_gnt/d_rvalid never high.
- Store, memory with 3 wait cycles: d_req, d_we=1, d_addr=0x400004, d_wmask=0100, d_wdata=0xAB0000 -> m_* stable for 4 cycles; d_gnt only on the m_ack cycle; no d_rvalid; back to IDLE the next cycle.
- Simultaneous requests, STARVE_MAX=4, both held continuously with zero-wait reads -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt cleared after each I grant.
- Spurious m_rvalid in IDLE and in ISSUE before m_ack -> no rvalid output, state unchanged.
- Reset asserted in WAIT for an outstanding load; m_rvalid returned the following cycle -> all outputs at reset values; d_rvalid stays 0; a new i_req issues normally afterwards.
